// File: rtl/clkgen_prog.sv
// clkgen_prog: serial programmer for a DCM_CLKGEN.
// After an accepted START it shifts the divide (D-1) and multiply (M-1) words
// into the DCM over PROGEN/PROGDATA, issues the GO command, then waits for
// the PROGDONE low/high handshake and, optionally, for LOCKED.
// A single wait counter bounds the whole post-GO wait; expiry raises ERR.
//
// Handshake: START is a request qualified by BUSY. A START sampled high at a
// rising CLK edge while BUSY=0 is accepted and the inputs MULT_M1/DIV_M1 are
// captured on that edge; START while BUSY=1 is dropped, never queued. Each
// accepted request ends with exactly one of DONE (one-cycle pulse) or ERR
// (sticky until the next accepted START or RESET); a reset abort ends it
// with neither.
module clkgen_prog #(
  parameter int TIMEOUT_W = 16,
  parameter bit WAIT_LOCK = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] MULT_M1,
  input  logic [7:0] DIV_M1,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       PROGEN,
  output logic       PROGDATA,
  input  logic       PROGDONE,
  input  logic       LOCKED,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD_D  = 4'd1;
  localparam logic [3:0] GAP_D   = 4'd2;
  localparam logic [3:0] LOAD_M  = 4'd3;
  localparam logic [3:0] GAP_M   = 4'd4;
  localparam logic [3:0] GO      = 4'd5;
  localparam logic [3:0] WAIT_LO = 4'd6;
  localparam logic [3:0] WAIT_HI = 4'd7;
  localparam logic [3:0] WAIT_LK = 4'd8;

  // The wait counter holds the number of wait cycles already spent; the wait
  // fails at the end of cycle number 2^TIMEOUT_W-1, i.e. when it reads 2^W-2.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [3:0]           state;
  logic [3:0]           bit_cnt;   // position inside a 10-bit load word
  logic [8:0]           shreg;     // remaining bits of the word being shifted
  logic [7:0]           mult_q;    // M-1 captured at START, loaded after GAP_D
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 wait_met;

  assign BUSY      = (state != IDLE);
  assign dbg_state = state;

  // Exit condition of whichever wait state is active.
  always_comb begin
    wait_met = 1'b0;
    case (state)
      WAIT_LO: wait_met = !PROGDONE;
      WAIT_HI: wait_met = PROGDONE;
      WAIT_LK: wait_met = LOCKED;
      default: wait_met = 1'b0;
    endcase
  end

  // Sequencer: state, serial shifter and registered PROGEN/PROGDATA/DONE/ERR.
  // The outputs are loaded together with the state they belong to, so each
  // state's PROGEN/PROGDATA values appear during that state with no
  // combinational path from any input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 9'd0;
      mult_q   <= 8'd0;
      wait_cnt <= '0;
      PROGEN   <= 1'b0;
      PROGDATA <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          PROGEN   <= 1'b0;
          PROGDATA <= 1'b0;
          if (START) begin
            mult_q <= MULT_M1;
            if (MULT_M1 == 8'd0) begin
              // M=1 cannot be programmed: flag it and stay idle.
              ERR <= 1'b1;
            end else begin
              ERR      <= 1'b0;
              state    <= LOAD_D;
              PROGEN   <= 1'b1;
              PROGDATA <= 1'b1;                 // divide word: 1, 0, D-1 LSB first
              shreg    <= {DIV_M1, 1'b0};
              bit_cnt  <= 4'd0;
            end
          end
        end
        LOAD_D, LOAD_M: begin
          if (bit_cnt == 4'd9) begin
            state    <= (state == LOAD_D) ? GAP_D : GAP_M;
            PROGEN   <= 1'b0;
            PROGDATA <= 1'b0;
          end else begin
            PROGDATA <= shreg[0];
            shreg    <= {1'b0, shreg[8:1]};
            bit_cnt  <= bit_cnt + 4'd1;
          end
        end
        GAP_D: begin
          state    <= LOAD_M;
          PROGEN   <= 1'b1;
          PROGDATA <= 1'b1;                     // multiply word: 1, 1, M-1 LSB first
          shreg    <= {mult_q, 1'b1};
          bit_cnt  <= 4'd0;
        end
        GAP_M: begin
          state    <= GO;
          PROGEN   <= 1'b1;
          PROGDATA <= 1'b0;
        end
        GO: begin
          state    <= WAIT_LO;
          PROGEN   <= 1'b0;
          PROGDATA <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT_LO, WAIT_HI, WAIT_LK: begin
          wait_cnt <= wait_cnt + WAIT_ONE;
          if (wait_met) begin
            if (state == WAIT_LO) begin
              state <= WAIT_HI;
            end else if (state == WAIT_HI && WAIT_LOCK) begin
              state <= WAIT_LK;
            end else begin
              state <= IDLE;
              DONE  <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= IDLE;
            ERR   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          PROGEN   <= 1'b0;
          PROGDATA <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_prog.sv
// Testbench for clkgen_prog: randomized programming sequences against a
// DCM environment model; expected serial streams and outcomes are queued at
// stimulus time and popped by independent monitors.
module tb_clkgen_prog;

  logic       clk = 1'b0;
  logic       rst, start, start2, progdone, progdone2, locked;
  logic [7:0] mult_m1, div_m1;
  logic       busy, done, err, progen, progdata;
  logic       busy2, done2, err2, progen2, progdata2;
  logic [3:0] dbg_state, dbg_state2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit last_err = 1'b0;

  // Scoreboard queues: serial stream (23 cycles from accept) and outcome.
  logic [22:0] exp_en_q[$];
  logic [22:0] exp_dat_q[$];
  logic [1:0]  exp_kind_q[$];   // 1 = DONE, 2 = ERR
  int          exp_lo_q[$];
  int          exp_hi_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  clkgen_prog #(.TIMEOUT_W(4), .WAIT_LOCK(1'b1)) dut (
    .CLK(clk), .RESET(rst), .START(start), .MULT_M1(mult_m1), .DIV_M1(div_m1),
    .BUSY(busy), .DONE(done), .ERR(err), .PROGEN(progen), .PROGDATA(progdata),
    .PROGDONE(progdone), .LOCKED(locked), .dbg_state(dbg_state)
  );

  clkgen_prog #(.TIMEOUT_W(4), .WAIT_LOCK(1'b0)) dut_nl (
    .CLK(clk), .RESET(rst), .START(start2), .MULT_M1(mult_m1), .DIV_M1(div_m1),
    .BUSY(busy2), .DONE(done2), .ERR(err2), .PROGEN(progen2), .PROGDATA(progdata2),
    .PROGDONE(progdone2), .LOCKED(1'b0), .dbg_state(dbg_state2)
  );

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Serial stream seen from the accept cycle: D word (10), gap, M word (10), gap, GO.
  function automatic void build_stream(input logic [7:0] m, input logic [7:0] d,
                                       output logic [22:0] en, output logic [22:0] dat);
    en  = '0;
    dat = '0;
    for (int i = 0; i < 10; i++) begin
      en[i]      = 1'b1;
      en[11 + i] = 1'b1;
    end
    en[22]  = 1'b1;
    dat[0]  = 1'b1;
    dat[11] = 1'b1;
    dat[12] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      dat[2 + b]  = d[b];
      dat[13 + b] = m[b];
    end
  endfunction

  // ---------------- monitors ----------------
  bit          capturing = 1'b0;
  int          cap_n = 0;
  logic [22:0] cap_en, cap_dat;

  // Serial-stream monitor: records 23 cycles from the first PROGEN high.
  always @(negedge clk) begin
    if (!capturing && progen === 1'b1) begin
      capturing = 1'b1;
      cap_n = 0;
    end
    if (capturing) begin
      cap_en[cap_n]  = progen;
      cap_dat[cap_n] = progdata;
      cap_n++;
      if (cap_n == 23) begin
        capturing = 1'b0;
        if (exp_en_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected: got en=0x%0h dat=0x%0h expected no PROGEN activity", cap_en, cap_dat);
        end else begin
          chk("stream_progen", 32'(cap_en), 32'(exp_en_q.pop_front()));
          chk("stream_progdata", 32'(cap_dat), 32'(exp_dat_q.pop_front()));
        end
      end
    end
  end

  logic err_prev = 1'b0;

  // Outcome monitor: DONE pulses and ERR rising edges.
  always @(negedge clk) begin
    logic [1:0] kind;
    int lo, hi;
    kind = 2'd0;
    if (done === 1'b1 && err === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_err_exclusive: got DONE=1 ERR=1 expected only one");
    end
    if (done === 1'b1) kind = 2'd1;
    else if (err === 1'b1 && err_prev !== 1'b1) kind = 2'd2;
    err_prev = err;
    if (kind != 2'd0) begin
      if (exp_kind_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL outcome_unexpected: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        lo = exp_lo_q.pop_front();
        hi = exp_hi_q.pop_front();
        chk("outcome_kind", 32'(kind), 32'(exp_kind_q.pop_front()));
        checks++;
        if (cyc < lo || cyc > hi) begin
          failures++;
          $display("FAIL outcome_time: got cycle %0d expected %0d..%0d", cyc, lo, hi);
        end
        chk("outcome_busy", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Lo/hi/lk: extra cycles the DCM model spends in each wait phase.
  task automatic run_seq(input logic [7:0] m_in, input logic [7:0] d, input int lo,
                         input int hi, input int lk, input bit never, input bit stray);
    logic [7:0]  m;
    logic [22:0] en_e, dat_e;
    int          c0, t_sum, end_idx, last_idx;
    bit          is_done;
    m = m_in;
    // Two illegal requests back to back would leave ERR high with no new edge.
    if (m == 8'd0 && last_err) m = 8'd1;
    c0 = cyc;
    mult_m1 = m;
    div_m1  = d;
    start   = 1'b1;
    if (m == 8'd0) begin
      exp_kind_q.push_back(2'd2);
      exp_lo_q.push_back(c0 + 1);
      exp_hi_q.push_back(c0 + 2);
      last_err = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      return;
    end
    build_stream(m, d, en_e, dat_e);
    exp_en_q.push_back(en_e);
    exp_dat_q.push_back(dat_e);
    t_sum   = lo + hi + lk + 3;
    is_done = !never && (t_sum <= 15);
    end_idx = is_done ? 23 + t_sum : 23 + 15;
    exp_kind_q.push_back(is_done ? 2'd1 : 2'd2);
    exp_lo_q.push_back(c0 + 1 + end_idx);
    exp_hi_q.push_back(c0 + 1 + end_idx);
    last_err = !is_done;
    @(negedge clk);
    start = 1'b0;
    last_idx = never ? end_idx + 2 : ((end_idx > 25 + lo + hi + lk) ? end_idx : 25 + lo + hi + lk) + 2;
    for (int idx = 0; idx <= last_idx; idx++) begin
      mult_m1 = 8'($urandom);
      div_m1  = 8'($urandom);
      if (!never && idx == 23 + lo) begin
        progdone = 1'b0;
        locked   = 1'b0;
      end
      if (!never && idx == 24 + lo + hi) progdone = 1'b1;
      if (!never && idx == 25 + lo + hi + lk) locked = 1'b1;
      start = stray && (idx < end_idx) && (idx == end_idx - 1 || $urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start    = 1'b0;
    progdone = 1'b1;
    locked   = 1'b1;
    @(negedge clk);
  endtask

  // Reset asserted in the 5th LOAD_M cycle, then a full nominal sequence.
  task automatic run_abort(input logic [7:0] m, input logic [7:0] d);
    logic [22:0] en_e, dat_e;
    build_stream(m, d, en_e, dat_e);
    for (int i = 16; i < 23; i++) begin
      en_e[i]  = 1'b0;
      dat_e[i] = 1'b0;
    end
    exp_en_q.push_back(en_e);
    exp_dat_q.push_back(dat_e);
    mult_m1 = m;
    div_m1  = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_progen", 32'(progen), 32'd0);
    chk("abort_progdata", 32'(progdata), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    last_err = 1'b0;
    repeat (10) @(negedge clk);
    run_seq(m, d, 1, 2, 1, 1'b0, 1'b0);
  endtask

  // WAIT_LOCK=0 instance: DONE one cycle after PROGDONE rises.
  task automatic run_no_lock();
    mult_m1 = 8'h27;
    div_m1  = 8'h07;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int idx = 0; idx <= 30; idx++) begin
      if (idx == 25) progdone2 = 1'b0;
      if (idx == 28) begin
        chk("nl_done_early", 32'(done2), 32'd0);
        progdone2 = 1'b1;
      end
      if (idx == 29) begin
        chk("nl_done", 32'(done2), 32'd1);
        chk("nl_busy", 32'(busy2), 32'd0);
        chk("nl_err", 32'(err2), 32'd0);
      end
      if (idx == 30) chk("nl_done_pulse", 32'(done2), 32'd0);
      @(negedge clk);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    progdone = 1'b1; progdone2 = 1'b1; locked = 1'b1;
    mult_m1 = 8'h00; div_m1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_progen", 32'(progen), 32'd0);
    chk("reset_progdata", 32'(progdata), 32'd0);
    chk("reset_busy_nl", 32'(busy2), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(8'h27, 8'h07, 2, 3, 2, 1'b0, 1'b0);   // nominal
    run_seq(8'h00, 8'h55, 0, 0, 0, 1'b0, 1'b0);   // illegal M
    run_seq(8'h27, 8'h07, 1, 1, 1, 1'b0, 1'b0);   // recovers after ERR
    run_seq(8'h80, 8'hff, 0, 0, 0, 1'b1, 1'b0);   // PROGDONE stuck high
    run_seq(8'hff, 8'h00, 4, 4, 4, 1'b0, 1'b0);   // wait ends on the last allowed cycle
    run_seq(8'h01, 8'h80, 4, 4, 5, 1'b0, 1'b0);   // one cycle too late
    run_seq(8'h27, 8'h07, 2, 2, 2, 1'b0, 1'b1);   // START pulses while busy
    run_abort(8'h27, 8'h07);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_seq(m, 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 6), 1'b0, 1'($urandom_range(0, 1)));
    end

    run_no_lock();
    repeat (30) @(negedge clk);

    chk("pending_streams", 32'(exp_en_q.size()), 32'd0);
    chk("pending_outcomes", 32'(exp_kind_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
